// File: rtl/bf8b_pkg.sv
// Shared types and helpers for the memory arbiter: FSM encoding and grant sizing.
package bf8b_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Latency counter holds values up to 15.
  localparam int unsigned CNT_W = 4;

  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side request bus plus memory-side bus of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned A_WIDTH    = 8,
  parameter int unsigned CLIENT_CNT = 2
);

  logic [CLIENT_CNT-1:0]         requests;
  logic [CLIENT_CNT*A_WIDTH-1:0] addrs;
  logic [CLIENT_CNT-1:0]         wes;
  logic [CLIENT_CNT*D_WIDTH-1:0] data_outs;
  logic [CLIENT_CNT-1:0]         readies;
  logic [D_WIDTH-1:0]            rdata;
  logic [A_WIDTH-1:0]            mem_addr;
  logic                          mem_we;
  logic [D_WIDTH-1:0]            mem_wdata;
  logic [D_WIDTH-1:0]            mem_rdata;
  logic                          busy;

  // Clients and memory model drive the master side.
  modport master (
    output requests, addrs, wes, data_outs, mem_rdata,
    input  readies, rdata, mem_addr, mem_we, mem_wdata, busy
  );

  modport slave (
    input  requests, addrs, wes, data_outs, mem_rdata,
    output readies, rdata, mem_addr, mem_we, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from last_grant+1, or highest index wins.
module rr_pick
  import bf8b_pkg::*;
#(
  parameter int unsigned CLIENT_CNT = 2,
  parameter int unsigned RR_EN      = 1,
  parameter int unsigned GW         = grant_width(CLIENT_CNT)
) (
  input  logic [CLIENT_CNT-1:0] requests,
  input  logic [GW-1:0]         last_grant,
  output logic [GW-1:0]         winner
);

  logic [GW-1:0] rr_win;
  logic [GW-1:0] fp_win;
  logic [GW-1:0] pick;
  int            idx;

  // Downward scans let the last hit be the preferred one.
  always_comb begin
    rr_win = '0;
    fp_win = '0;
    pick   = '0;
    idx    = 0;
    for (int k = int'(CLIENT_CNT); k >= 1; k--) begin
      idx  = (int'(last_grant) + k) % int'(CLIENT_CNT);
      pick = GW'(idx);
      if (requests[pick]) rr_win = pick;
    end
    for (int k = 0; k < int'(CLIENT_CNT); k++) begin
      if (requests[GW'(k)]) fp_win = GW'(k);
    end
    winner = (RR_EN != 0) ? rr_win : fp_win;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CLIENT_CNT requesters onto one fixed-latency memory port, one access at a time.
module mem_arbiter
  import bf8b_pkg::*;
#(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned A_WIDTH     = 8,
  parameter int unsigned CLIENT_CNT  = 2,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned RR_EN       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned GW = grant_width(CLIENT_CNT);

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [GW-1:0]         winner;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CLIENT_CNT-1:0] readies_q, readies_d;
  logic [D_WIDTH-1:0]    rdata_q, rdata_d;
  logic [D_WIDTH-1:0]    wdata_q, wdata_d;
  logic [A_WIDTH-1:0]    addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;

  logic [A_WIDTH-1:0]    addr_arr  [CLIENT_CNT];
  logic [D_WIDTH-1:0]    wdata_arr [CLIENT_CNT];

  for (genvar i = 0; i < CLIENT_CNT; i++) begin : g_unpack
    assign addr_arr[i]  = bus.addrs[i*A_WIDTH +: A_WIDTH];
    assign wdata_arr[i] = bus.data_outs[i*D_WIDTH +: D_WIDTH];
  end

  rr_pick #(
    .CLIENT_CNT (CLIENT_CNT),
    .RR_EN      (RR_EN),
    .GW         (GW)
  ) u_pick (
    .requests   (bus.requests),
    .last_grant (last_q),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next register values; mem_we defaults low so it pulses only on grant.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    readies_d = readies_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.requests) begin
          grant_d = winner;
          last_d  = winner;
          addr_d  = addr_arr[winner];
          wdata_d = wdata_arr[winner];
          we_d    = bus.wes[winner];
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d            = bus.mem_rdata;
          readies_d[grant_q] = 1'b1;
          state_d            = DONE;
        end
      end
      DONE: begin
        if (!bus.requests[grant_q]) begin
          readies_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      last_q    <= GW'(CLIENT_CNT - 1);
      cnt_q     <= '0;
      readies_q <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      readies_q <= readies_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.readies   = readies_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule
